// File: rtl/prog_sequencer.sv
// Round-robin launcher for the resident core programs: start edge -> PC load -> run until done -> halt ack.
// Optional RUN watchdog compiled in with `define PROG_SEQUENCER_WATCHDOG_EN.
module prog_sequencer #(
    parameter int PW      = 10,
    parameter int NPROG   = 3,
    parameter int START0  = 0,
    parameter int START1  = 128,
    parameter int START2  = 256,
    parameter int START3  = 384,
    parameter int TIMEOUT = 65535
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    input  logic          core_done,
    output logic          halt,
    output logic          run,
    output logic          pc_load,
    output logic [PW-1:0] pc_init,
    output logic [1:0]    prog_id,
    output logic [15:0]   run_cycles,
    output logic          timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    if (NPROG < 1 || NPROG > 4 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("prog_sequencer: NPROG must be 1..4 and TIMEOUT 1..65535");
    end

    logic [1:0]    state_q, state_d;
    logic          start_q;
    logic          halt_q, halt_d;
    logic          run_q, run_d;
    logic          pc_load_q, pc_load_d;
    logic [PW-1:0] pc_init_q, pc_init_d;
    logic [1:0]    prog_id_q, prog_id_d;
    logic [15:0]   run_cycles_q, run_cycles_d;
    logic          timeout_q, timeout_d;

    logic          go;
    logic [15:0]   cycles_inc;
    logic [1:0]    next_id;

    function automatic logic [PW-1:0] entry_addr(input logic [1:0] id);
        case (id)
            2'd0:    entry_addr = PW'(START0);
            2'd1:    entry_addr = PW'(START1);
            2'd2:    entry_addr = PW'(START2);
            default: entry_addr = PW'(START3);
        endcase
    endfunction

    assign go         = start & ~start_q;
    assign cycles_inc = (run_cycles_q == 16'hFFFF) ? run_cycles_q : run_cycles_q + 16'd1;
    assign next_id    = (prog_id_q == 2'(NPROG - 1)) ? 2'd0 : prog_id_q + 2'd1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        halt_d       = halt_q;
        run_d        = run_q;
        pc_load_d    = 1'b0;
        pc_init_d    = pc_init_q;
        prog_id_d    = prog_id_q;
        run_cycles_d = run_cycles_q;
        timeout_d    = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d      = S_LOAD;
                    halt_d       = 1'b0;
                    pc_load_d    = 1'b1;
                    pc_init_d    = entry_addr(prog_id_q);
                    run_cycles_d = '0;
                    timeout_d    = 1'b0;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
                run_d   = 1'b1;
            end
            S_RUN: begin
                run_cycles_d = cycles_inc;
                if (core_done) begin
                    state_d   = S_DONE;
                    run_d     = 1'b0;
                    halt_d    = 1'b1;
                    prog_id_d = next_id;
                end
`ifdef PROG_SEQUENCER_WATCHDOG_EN
                // Expiry is judged on the updated count so run_cycles lands exactly on TIMEOUT.
                else if (cycles_inc == 16'(TIMEOUT)) begin
                    state_d   = S_DONE;
                    run_d     = 1'b0;
                    halt_d    = 1'b1;
                    prog_id_d = next_id;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            halt_q       <= 1'b0;
            run_q        <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_init_q    <= '0;
            prog_id_q    <= 2'd0;
            run_cycles_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            halt_q       <= halt_d;
            run_q        <= run_d;
            pc_load_q    <= pc_load_d;
            pc_init_q    <= pc_init_d;
            prog_id_q    <= prog_id_d;
            run_cycles_q <= run_cycles_d;
            timeout_q    <= timeout_d;
        end
    end

    assign halt       = halt_q;
    assign run        = run_q;
    assign pc_load    = pc_load_q;
    assign pc_init    = pc_init_q;
    assign prog_id    = prog_id_q;
    assign run_cycles = run_cycles_q;
`ifdef PROG_SEQUENCER_WATCHDOG_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
    logic unused_timeout;
    assign unused_timeout = timeout_q ^ timeout_d;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: table of program launches plus hand-written corner sequences.
module tb_prog_sequencer;

`ifdef PROG_SEQUENCER_WATCHDOG_EN
    localparam int TB_TIMEOUT = 50;
`else
    localparam int TB_TIMEOUT = 65535;
`endif

    logic        CLK;
    logic        reset;
    logic        start;
    logic        core_done;
    logic        halt;
    logic        run;
    logic        pc_load;
    logic [9:0]  pc_init;
    logic [1:0]  prog_id;
    logic [15:0] run_cycles;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    prog_sequencer #(.PW(10), .NPROG(3), .TIMEOUT(TB_TIMEOUT)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .core_done  (core_done),
        .halt       (halt),
        .run        (run),
        .pc_load    (pc_load),
        .pc_init    (pc_init),
        .prog_id    (prog_id),
        .run_cycles (run_cycles),
        .timeout    (timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int         run_len;
        logic [9:0] exp_pc;
        logic [1:0] exp_id;
        logic [1:0] exp_next;
    } prog_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Launch from IDLE/DONE, run for n RUN edges with core_done on the last one, check the ack.
    task automatic run_prog(input int n, input logic [9:0] exp_pc,
                            input logic [1:0] exp_id, input logic [1:0] exp_next);
        check("prog_id_pre", 32'(prog_id), 32'(exp_id));
        start = 1'b1;
        tick();
        check("load_pc_load", 32'(pc_load), 1);
        check("load_pc_init", 32'(pc_init), 32'(exp_pc));
        check("load_halt", 32'(halt), 0);
        check("load_run", 32'(run), 0);
        check("load_cycles", 32'(run_cycles), 0);
        check("load_timeout", 32'(timeout), 0);
        start = 1'b0;
        tick();
        check("run_first", 32'(run), 1);
        check("run_pc_load", 32'(pc_load), 0);
        for (int i = 1; i <= n; i++) begin
            core_done = (i == n);
            tick();
            if (i < n) begin
                check("run_mid", 32'(run), 1);
                check("run_mid_cycles", 32'(run_cycles), 32'(i));
            end
        end
        core_done = 1'b0;
        check("done_halt", 32'(halt), 1);
        check("done_run", 32'(run), 0);
        check("done_cycles", 32'(run_cycles), 32'(n));
        check("done_prog_id", 32'(prog_id), 32'(exp_next));
    endtask

    initial begin
        prog_vec_t vecs[4];
        int bad;

        vecs[0] = '{run_len: 20, exp_pc: 10'd0,   exp_id: 2'd0, exp_next: 2'd1};
        vecs[1] = '{run_len: 5,  exp_pc: 10'd128, exp_id: 2'd1, exp_next: 2'd2};
        vecs[2] = '{run_len: 1,  exp_pc: 10'd256, exp_id: 2'd2, exp_next: 2'd0};
        vecs[3] = '{run_len: 3,  exp_pc: 10'd0,   exp_id: 2'd0, exp_next: 2'd1};

        reset = 1'b1;
        start = 1'b0;
        core_done = 1'b0;
        tick();
        tick();
        check("rst_halt", 32'(halt), 0);
        check("rst_run", 32'(run), 0);
        check("rst_pc_load", 32'(pc_load), 0);
        check("rst_pc_init", 32'(pc_init), 0);
        check("rst_prog_id", 32'(prog_id), 0);
        check("rst_cycles", 32'(run_cycles), 0);
        check("rst_timeout", 32'(timeout), 0);
        reset = 1'b0;
        tick();
        check("idle_no_go", 32'(pc_load), 0);

        // Back-to-back round robin, including wrap to program 0.
        for (int v = 0; v < 4; v++)
            run_prog(vecs[v].run_len, vecs[v].exp_pc, vecs[v].exp_id, vecs[v].exp_next);

        // Start edges during RUN are ignored; a level held across DONE entry is not a go.
        start = 1'b1;
        tick();
        check("ign_load_pc", 32'(pc_init), 128);
        start = 1'b0;
        tick();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("ign_run", 32'(run), 1);
        check("ign_pc_load", 32'(pc_load), 0);
        check("ign_halt", 32'(halt), 0);
        repeat (2) tick();
        start = 1'b1;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("ign_done_halt", 32'(halt), 1);
        check("ign_done_cycles", 32'(run_cycles), 8);
        check("ign_done_id", 32'(prog_id), 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("held_halt", 32'(halt), 1);
            check("held_pc_load", 32'(pc_load), 0);
        end
        start = 1'b0;
        tick();
        check("held_release_halt", 32'(halt), 1);
        check("held_release_load", 32'(pc_load), 0);
        run_prog(2, 10'd256, 2'd2, 2'd0);

        // Reset mid-RUN of program 1 abandons it and restarts the round robin.
        run_prog(2, 10'd0, 2'd0, 2'd1);
        start = 1'b1;
        tick();
        check("p1_pc_init", 32'(pc_init), 128);
        start = 1'b0;
        tick();
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_run", 32'(run), 0);
        check("mid_rst_halt", 32'(halt), 0);
        check("mid_rst_id", 32'(prog_id), 0);
        check("mid_rst_cycles", 32'(run_cycles), 0);
        tick();
        run_prog(4, 10'd0, 2'd0, 2'd1);

`ifdef PROG_SEQUENCER_WATCHDOG_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (49) tick();
        check("wd_before_run", 32'(run), 1);
        check("wd_before_cycles", 32'(run_cycles), 49);
        tick();
        check("wd_halt", 32'(halt), 1);
        check("wd_run", 32'(run), 0);
        check("wd_timeout", 32'(timeout), 1);
        check("wd_cycles", 32'(run_cycles), 50);
        check("wd_prog_id", 32'(prog_id), 2);
        start = 1'b1;
        tick();
        check("wd_clear_timeout", 32'(timeout), 0);
        check("wd_next_pc", 32'(pc_init), 256);
        start = 1'b0;
        tick();
`else
        // No watchdog: RUN persists and run_cycles saturates.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        bad = 0;
        for (int i = 1; i <= 70000; i++) begin
            tick();
            if (run !== 1'b1 || halt !== 1'b0 || timeout !== 1'b0) bad++;
            if (i == 65534) check("sat_pre", 32'(run_cycles), 65534);
        end
        check("sat_bad_cycles", 32'(bad), 0);
        check("sat_cycles", 32'(run_cycles), 65535);
        check("sat_halt", 32'(halt), 0);
        check("sat_timeout", 32'(timeout), 0);
        check("sat_prog_id", 32'(prog_id), 1);
`endif

        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Sequences the three resident programs (Hamming encode, Hamming decode/correct, pattern count) on the processor core. Sits between the bench/host request handshake (`start`/`halt`) and the core's program-counter and run-enable controls. Each `start` pulse launches the next program in round-robin order from its fixed entry address, runs the core until it signals completion, then raises `halt` as acknowledge.

## Interface
- `PW`, 10: program-counter width.
- `NPROG`, 3: number of programs; legal range 1..4.
- `START0`, 0: entry address of program 0.
- `START1`, 128: entry address of program 1.
- `START2`, 256: entry address of program 2.
- `START3`, 384: entry address of program 3.
- `TIMEOUT`, 65535: watchdog limit in RUN cycles; used only when the watchdog is compiled in.

Ports:
- `CLK`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request from host; acted on at its rising edge only.
- `core_done`  in  1  core executed its terminating instruction; sampled only in RUN.
- `halt`  out  1  acknowledge: program finished; held until the next accepted `start`.
- `run`  out  1  core execute enable.
- `pc_load`  out  1  one-cycle strobe that loads `pc_init` into the core PC.
- `pc_init`  out  PW  entry address for the program being launched.
- `prog_id`  out  2  index of the program to run on the next accepted `start`.
- `run_cycles`  out  16  RUN-cycle count of the current or last program, saturating at 0xFFFF.
- `timeout`  out  1  last program was ended by the watchdog.

## Operation
- States: IDLE, LOAD, RUN, DONE. All outputs are registered.
- Edge detect: `start_q` holds the registered `start`. `go = start & ~start_q`.
- IDLE: on `go`, go to LOAD. Otherwise stay.
- LOAD: lasts exactly one cycle. Drives `pc_load=1` and `pc_init=STARTn` for n = `prog_id`. Clears `run_cycles` and `timeout`. Then goes to RUN.
- RUN: `run=1`. `run_cycles` increments each cycle up to saturation. When `core_done=1` is sampled, go to DONE.
- DONE: `halt=1`, `run=0`. On entry, `prog_id` advances: it wraps to 0 when it equals NPROG-1, otherwise it increments. On `go`, go to LOAD and `halt` drops.
- `start` edges that occur in LOAD or RUN are ignored and are not queued. `start_q` still tracks `start`, so a level held across DONE entry does not create a `go`.
- `core_done` is ignored in IDLE, LOAD and DONE.
- When `core_done` and the watchdog expiry occur in the same cycle, `core_done` wins and `timeout` stays 0.
- `reset` in any state: all registers return to their reset values on that edge, and the program in flight is abandoned.

## Timing
- Reset values: state=IDLE, `halt=0`, `run=0`, `pc_load=0`, `pc_init=0`, `prog_id=0`, `run_cycles=0`, `timeout=0`, `start_q=0`.
- Let edge E be the clock edge that samples `go`:
  - E+1: LOAD outputs visible, and `halt` is 0 from E+1 onward.
  - E+2: first cycle with `run=1`.
- Let edge D be the clock edge that samples `core_done=1`:
  - D+1: `halt=1`, `run=0`, `prog_id` advanced.
- `run_cycles` equals the number of cycles `run` was high, which is the number of RUN clock edges.
- Start-to-ack latency is 2 + (RUN cycles) clock cycles.

## Configuration
- `PROG_SEQUENCER_WATCHDOG_EN` defined:
  - A RUN that reaches `run_cycles == TIMEOUT` without `core_done` goes to DONE on the next edge.
  - That transition sets `timeout=1` and advances `prog_id` as for a normal completion.
- Macro undefined:
  - No watchdog logic. `timeout` is tied to 0.
  - RUN waits for `core_done` indefinitely. The `TIMEOUT` parameter is unused.

## Test plan
- Reset, then pulse `start` for 1 cycle → `pc_load` is high for exactly 1 cycle with `pc_init=0` and `prog_id=0`. Assert `core_done` after 20 RUN cycles → `halt=1`, `run_cycles=20`, `prog_id=1`.
- Run three back-to-back programs → `pc_init` is 0, 128, 256 in turn. The fourth `start` → `pc_init=0` (wrap), and `halt` falls one cycle after each `go`.
- Pulse `start` during RUN, and hold `start` high for 5 cycles across DONE entry → no relaunch, and `halt` stays 1 until a fresh rising edge.
- Assert `reset` for 1 cycle mid-RUN of program 1 → next edge shows `run=0`, `halt=0`, `prog_id=0`. The next `start` launches from address 0.
- With `PROG_SEQUENCER_WATCHDOG_EN` defined and TIMEOUT=50, never assert `core_done` → DONE after 50 RUN cycles with `timeout=1`, `run_cycles=50`, `prog_id` advanced. The next program clears `timeout` in LOAD.
- With the watchdog macro undefined, hold `core_done` low for 70000 cycles → `run=1` throughout, `run_cycles` saturates at 65535, `halt=0`, `timeout=0`.
